// File: rtl/ptp_echo_timer.sv
// ptp_echo_timer
// Times a run of 2**ROUNDS_LOG2 ping/echo exchanges on a piezo line and
// reports the sum and truncated average of the captured intervals. The same
// instance acts as master (sends pings, times echoes) or slave (waits for a
// ping, replies, then times each following ping against its own reply).
//
// Ports:
//   clock        single clock for all logic
//   reset        asynchronous, active-low
//   enable       0 forces the block back to IDLE, same as abort
//   master_mode  role select, sampled when start is accepted (1 = master)
//   start        single-cycle request, accepted only in IDLE with enable = 1
//   abort        synchronous return to IDLE, wins over start
//   piezo_in     asynchronous echo/ping input
//   piezo_out    registered pulse output
//   busy         high whenever the controller is not idle
//   result_valid one-cycle pulse when a measurement completes
//   result_sum   sum of the captured intervals
//   result_avg   result_sum >> ROUNDS_LOG2, truncated
//   timeout_err  sticky listen-timeout flag, cleared by the next accepted start
module ptp_echo_timer #(
    parameter int CNT_W       = 32,
    parameter int PULSE_LEN   = 6,
    parameter int BLANK_LEN   = 16,
    parameter int TIMEOUT     = 100000,
    parameter int ROUNDS_LOG2 = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         master_mode,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         piezo_in,
    output logic                         piezo_out,
    output logic                         busy,
    output logic                         result_valid,
    output logic [CNT_W+ROUNDS_LOG2-1:0] result_sum,
    output logic [CNT_W-1:0]             result_avg,
    output logic                         timeout_err
);

    localparam int SUM_W = CNT_W + ROUNDS_LOG2;
    localparam int RND_W = ROUNDS_LOG2 + 1;

    // The interval counter runs from TX entry, so the TX and BLANK phase
    // ends are fixed counter values and need no separate phase counter.
    localparam logic [CNT_W-1:0] TX_LAST     = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(PULSE_LEN + BLANK_LEN - 1);
    localparam logic [CNT_W-1:0] LISTEN_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [RND_W-1:0] ROUNDS      = RND_W'(2 ** ROUNDS_LOG2);
    localparam logic [RND_W-1:0] ROUND_LAST  = RND_W'(2 ** ROUNDS_LOG2 - 1);
    localparam logic [RND_W-1:0] ROUND_ONE   = RND_W'(1);
    localparam bit               HAS_BLANK   = (BLANK_LEN != 32'sd0);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FIRST = 3'd1,
        ST_TX         = 3'd2,
        ST_BLANK      = 3'd3,
        ST_LISTEN     = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [SYNC_STAGES-1:0]   sync_r;
    logic                     sync_d_r;
    logic                     rise_s;
    logic                     kill_s;
    logic                     start_ok_s;
    logic                     capture_s;
    logic                     timeout_s;
    logic [SUM_W-1:0]         sum_nxt_s;
    logic [CNT_W-1:0]         cnt_r;
    logic [SUM_W-1:0]         sum_acc_r;
    logic [RND_W-1:0]         round_r;
    logic                     master_r;
    logic                     piezo_out_r;
    logic                     busy_r;
    logic                     result_valid_r;
    logic [SUM_W-1:0]         result_sum_r;
    logic [CNT_W-1:0]         result_avg_r;
    logic                     timeout_err_r;

    // Input synchroniser chain and its delayed last stage for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_r   <= {SYNC_STAGES{1'b0}};
            sync_d_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], piezo_in};
            sync_d_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise_s = sync_r[SYNC_STAGES-1] & ~sync_d_r;

    // Next-state decode; rise only matters in WAIT_FIRST and LISTEN
    always_comb begin
        kill_s      = abort | ~enable;
        start_ok_s  = (state_r == ST_IDLE) && start && !kill_s;
        capture_s   = (state_r == ST_LISTEN) && rise_s;
        // A rise on the last listen cycle is still a capture, not a timeout.
        timeout_s   = (state_r == ST_LISTEN) && !rise_s && (cnt_r == LISTEN_LAST);
        sum_nxt_s   = capture_s ? (sum_acc_r + SUM_W'(cnt_r)) : sum_acc_r;
        state_nxt_s = state_r;
        if (kill_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) state_nxt_s = master_mode ? ST_TX : ST_WAIT_FIRST;
                    else            state_nxt_s = ST_IDLE;
                end
                ST_WAIT_FIRST: begin
                    if (rise_s) state_nxt_s = ST_TX;
                    else        state_nxt_s = ST_WAIT_FIRST;
                end
                ST_TX: begin
                    // Only a slave reaches TX with all rounds counted: that is
                    // the reply to its final capture, which ends the run.
                    if (cnt_r == TX_LAST) begin
                        if (round_r == ROUNDS) state_nxt_s = ST_DONE;
                        else if (HAS_BLANK)    state_nxt_s = ST_BLANK;
                        else                   state_nxt_s = ST_LISTEN;
                    end else begin
                        state_nxt_s = ST_TX;
                    end
                end
                ST_BLANK: begin
                    if (cnt_r == BLANK_LAST) state_nxt_s = ST_LISTEN;
                    else                     state_nxt_s = ST_BLANK;
                end
                ST_LISTEN: begin
                    if (capture_s) begin
                        if (master_r && (round_r == ROUND_LAST)) state_nxt_s = ST_DONE;
                        else                                     state_nxt_s = ST_TX;
                    end else if (timeout_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_LISTEN;
                    end
                end
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Controller state, interval counter, accumulators and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            sum_acc_r      <= {SUM_W{1'b0}};
            round_r        <= {RND_W{1'b0}};
            master_r       <= 1'b0;
            piezo_out_r    <= 1'b0;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
            result_sum_r   <= {SUM_W{1'b0}};
            result_avg_r   <= {CNT_W{1'b0}};
            timeout_err_r  <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            busy_r         <= (state_nxt_s != ST_IDLE);
            piezo_out_r    <= (state_nxt_s == ST_TX);
            result_valid_r <= (state_nxt_s == ST_DONE);

            // Every TX entry comes from another state, so this marks a new ping.
            if ((state_nxt_s == ST_TX) && (state_r != ST_TX)) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end

            if (start_ok_s) begin
                sum_acc_r     <= {SUM_W{1'b0}};
                round_r       <= {RND_W{1'b0}};
                timeout_err_r <= 1'b0;
                master_r      <= master_mode;
            end else begin
                if (capture_s) begin
                    sum_acc_r <= sum_nxt_s;
                    round_r   <= round_r + ROUND_ONE;
                end
                if (timeout_s && !kill_s) begin
                    timeout_err_r <= 1'b1;
                end
            end

            // Results change only on DONE entry and hold otherwise.
            if (state_nxt_s == ST_DONE) begin
                result_sum_r <= sum_nxt_s;
                result_avg_r <= CNT_W'(sum_nxt_s >> ROUNDS_LOG2);
            end
        end
    end

    assign piezo_out    = piezo_out_r;
    assign busy         = busy_r;
    assign result_valid = result_valid_r;
    assign result_sum   = result_sum_r;
    assign result_avg   = result_avg_r;
    assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_ptp_echo_timer.sv
// Testbench for ptp_echo_timer: directed scenarios, each with an expected
// per-cycle trace built from the ping/echo timing rules (pulse windows,
// capture value = e + SYNC_STAGES - 1, round length = capture + 1).
module tb_ptp_echo_timer;

    localparam int CNT_W       = 16;
    localparam int PULSE_LEN   = 3;
    localparam int BLANK_LEN   = 4;
    localparam int TIMEOUT     = 64;
    localparam int ROUNDS_LOG2 = 2;
    localparam int SYNC_STAGES = 2;
    localparam int ROUNDS      = 4;
    localparam int MAXC        = 256;

    logic                         clock = 1'b0;
    logic                         reset = 1'b0;
    logic                         enable = 1'b1;
    logic                         master_mode = 1'b0;
    logic                         start = 1'b0;
    logic                         abort = 1'b0;
    logic                         piezo_in = 1'b0;
    logic                         piezo_out;
    logic                         busy;
    logic                         result_valid;
    logic [CNT_W+ROUNDS_LOG2-1:0] result_sum;
    logic [CNT_W-1:0]             result_avg;
    logic                         timeout_err;

    int     n_checks = 0;
    int     n_errors = 0;
    bit     exp_busy  [MAXC];
    bit     exp_pout  [MAXC];
    bit     exp_valid [MAXC];
    bit     exp_terr  [MAXC];
    longint exp_sum   [MAXC];
    bit     pin       [MAXC];
    longint prev_sum  = 0;
    bit     prev_terr = 1'b0;
    int     valid_cnt;
    int     first_pout;

    ptp_echo_timer #(
        .CNT_W(CNT_W), .PULSE_LEN(PULSE_LEN), .BLANK_LEN(BLANK_LEN),
        .TIMEOUT(TIMEOUT), .ROUNDS_LOG2(ROUNDS_LOG2), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .master_mode(master_mode),
        .start(start), .abort(abort), .piezo_in(piezo_in), .piezo_out(piezo_out),
        .busy(busy), .result_valid(result_valid), .result_sum(result_sum),
        .result_avg(result_avg), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected trace. Index j = outputs after edge j, where edge 0 samples start.
    // e_r < 0 means no echo in that round (listen times out).
    // abort_edge: 0 = start lost to abort, >0 = killed at that edge, <0 = none.
    task automatic build(input bit mm, input int first_ping,
                         input int e0, input int e1, input int e2, input int e3,
                         input bit extra, input int abort_edge);
        int     e[4];
        int     t;
        int     c;
        int     done_c;
        int     stop_c;
        int     end_c;
        longint sum;
        e = '{e0, e1, e2, e3};
        for (int j = 0; j < MAXC; j++) begin
            exp_busy[j] = 1'b0; exp_pout[j] = 1'b0; exp_valid[j] = 1'b0;
            exp_terr[j] = prev_terr; exp_sum[j] = prev_sum; pin[j] = 1'b0;
        end
        if (abort_edge == 0) return;
        sum = 0; done_c = -1; stop_c = -1;
        if (mm) begin
            t = 0;
        end else begin
            pin[first_ping] = 1'b1;
            t = first_ping + SYNC_STAGES;
        end
        for (int r = 0; r < ROUNDS; r++) begin
            for (int j = t; j < t + PULSE_LEN; j++) exp_pout[j] = 1'b1;
            if (extra) begin
                pin[t + 1] = 1'b1;   // lands in TX
                pin[t + 4] = 1'b1;   // lands in BLANK
            end
            if (e[r] < 0) begin
                stop_c = t + TIMEOUT;
                break;
            end
            pin[t + e[r]] = 1'b1;
            c   = e[r] + SYNC_STAGES - 1;
            sum = sum + c;
            t   = t + c + 1;
            if (r == ROUNDS - 1) begin
                if (mm) begin
                    done_c = t;
                end else begin
                    for (int j = t; j < t + PULSE_LEN; j++) exp_pout[j] = 1'b1;
                    done_c = t + PULSE_LEN;
                end
            end
        end
        end_c = (stop_c >= 0) ? stop_c : done_c + 1;
        for (int j = 0; j < MAXC; j++) begin
            exp_busy[j] = (j < end_c);
            exp_terr[j] = (stop_c >= 0) && (j >= stop_c);
            if (done_c >= 0 && j >= done_c) exp_sum[j] = sum;
        end
        if (done_c >= 0) exp_valid[done_c] = 1'b1;
        if (abort_edge > 0) begin
            for (int j = abort_edge; j < MAXC; j++) begin
                exp_busy[j] = 1'b0; exp_pout[j] = 1'b0; exp_valid[j] = 1'b0;
                exp_sum[j]  = exp_sum[abort_edge - 1];
                exp_terr[j] = exp_terr[abort_edge - 1];
            end
        end
    endtask

    // Drives a scenario from a negedge and compares every cycle with the trace.
    task automatic run(input string tag, input bit mm, input int ncyc,
                       input int abort_edge, input bit via_en, input int restart_edge);
        valid_cnt   = 0;
        first_pout  = -1;
        master_mode = mm;
        start       = 1'b1;
        piezo_in    = pin[0];
        abort       = (abort_edge == 0) && !via_en;
        enable      = !((abort_edge == 0) && via_en);
        for (int j = 0; j < ncyc; j++) begin
            @(posedge clock);
            @(negedge clock);
            check($sformatf("%s c%0d busy", tag, j), busy, exp_busy[j]);
            check($sformatf("%s c%0d piezo_out", tag, j), piezo_out, exp_pout[j]);
            check($sformatf("%s c%0d result_valid", tag, j), result_valid, exp_valid[j]);
            check($sformatf("%s c%0d timeout_err", tag, j), timeout_err, exp_terr[j]);
            check($sformatf("%s c%0d result_sum", tag, j), result_sum, exp_sum[j]);
            check($sformatf("%s c%0d result_avg", tag, j), result_avg, exp_sum[j] / ROUNDS);
            if (result_valid) valid_cnt++;
            if (piezo_out && first_pout < 0) first_pout = j;
            start    = (j + 1 == restart_edge);
            piezo_in = pin[j + 1];
            abort    = (j + 1 == abort_edge) && !via_en;
            enable   = !((j + 1 == abort_edge) && via_en);
        end
        start = 1'b0; abort = 1'b0; enable = 1'b1; piezo_in = 1'b0;
        prev_sum  = exp_sum[ncyc - 1];
        prev_terr = exp_terr[ncyc - 1];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the end of the run");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset piezo_out", piezo_out, 0);
        check("reset busy", busy, 0);
        check("reset result_valid", result_valid, 0);
        check("reset timeout_err", timeout_err, 0);
        check("reset result_sum", result_sum, 0);
        check("reset result_avg", result_avg, 0);
        reset = 1'b1;
        @(negedge clock);

        // Master loopback, echo sampled at e = 20 each round; a second start mid-run is ignored.
        build(1'b1, 0, 20, 20, 20, 20, 1'b0, -1);
        run("loop", 1'b1, 96, -1, 1'b0, 10);
        check("loop sum literal", result_sum, 84);
        check("loop avg literal", result_avg, 21);
        check("loop valid pulses", valid_cnt, 1);
        check("loop timeout_err literal", timeout_err, 0);

        // Master timeout with piezo_in held low; previous result retained.
        build(1'b1, 0, -1, -1, -1, -1, 1'b0, -1);
        run("tmo", 1'b1, 70, -1, 1'b0, -1);
        check("tmo timeout_err literal", timeout_err, 1);
        check("tmo sum retained", result_sum, 84);
        check("tmo valid pulses", valid_cnt, 0);

        // start and abort together: stays idle, sticky error untouched.
        build(1'b1, 0, -1, -1, -1, -1, 1'b0, 0);
        run("startabort", 1'b1, 6, 0, 1'b0, -1);
        check("startabort busy literal", busy, 0);
        check("startabort timeout_err literal", timeout_err, 1);

        // Blanking: pulses during TX and BLANK are dropped, e = 40 captured.
        build(1'b1, 0, 40, 40, 40, 40, 1'b1, -1);
        run("blank", 1'b1, 175, -1, 1'b0, -1);
        check("blank sum literal", result_sum, 164);
        check("blank avg literal", result_avg, 41);
        check("blank timeout_err cleared", timeout_err, 0);

        // Slave: first ping sampled at edge 5, then pings at e = 30 after each reply.
        build(1'b0, 5, 30, 30, 30, 30, 1'b0, -1);
        run("slave", 1'b0, 145, -1, 1'b0, -1);
        check("slave first reply cycle", first_pout, 7);
        check("slave sum literal", result_sum, 124);
        check("slave avg literal", result_avg, 31);
        check("slave valid pulses", valid_cnt, 1);

        // Abort in the first TX cycle.
        build(1'b1, 0, -1, -1, -1, -1, 1'b0, 1);
        run("abort", 1'b1, 10, 1, 1'b0, -1);
        check("abort valid pulses", valid_cnt, 0);
        check("abort sum retained", result_sum, 124);

        // enable dropped during LISTEN.
        build(1'b1, 0, -1, -1, -1, -1, 1'b0, 10);
        run("enable", 1'b1, 20, 10, 1'b1, -1);
        check("enable valid pulses", valid_cnt, 0);

        // Truncating average: captures 10, 11, 11, 11.
        build(1'b1, 0, 9, 10, 10, 10, 1'b0, -1);
        run("trunc", 1'b1, 55, -1, 1'b0, -1);
        check("trunc sum literal", result_sum, 43);
        check("trunc avg literal", result_avg, 10);

        // Reset asserted mid-LISTEN clears every output without waiting for an edge.
        master_mode = 1'b1;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        check("pre-reset busy", busy, 1);
        reset = 1'b0;
        #1;
        check("async reset piezo_out", piezo_out, 0);
        check("async reset busy", busy, 0);
        check("async reset result_valid", result_valid, 0);
        check("async reset timeout_err", timeout_err, 0);
        check("async reset result_sum", result_sum, 0);
        check("async reset result_avg", result_avg, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("post-reset busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
